// File: rtl/wbu_commit_ctrl_pkg.sv
// Shared definitions for the writeback/commit sequencer: one-hot instruction
// class codes, FSM state encoding and a small class helper.
package wbu_commit_ctrl_pkg;

  // One-hot instruction class codes presented on inst_type.
  localparam logic [31:0] INST_ADDI  = 32'h0000_0001;
  localparam logic [31:0] INST_JALR  = 32'h0000_0002;
  localparam logic [31:0] INST_ADD   = 32'h0000_0008;
  localparam logic [31:0] INST_LUI   = 32'h0000_0010;
  localparam logic [31:0] INST_LW    = 32'h0000_0020;
  localparam logic [31:0] INST_LBU   = 32'h0000_0040;
  localparam logic [31:0] INST_AUIPC = 32'h0000_0200;
  localparam logic [31:0] INST_JAL   = 32'h0000_0400;
  localparam logic [31:0] INST_SUB   = 32'h0000_0800;
  localparam logic [31:0] INST_SLTI  = 32'h0000_1000;
  localparam logic [31:0] INST_SLTIU = 32'h0000_2000;
  localparam logic [31:0] INST_BEQ   = 32'h0000_4000;
  localparam logic [31:0] INST_BNE   = 32'h0000_8000;
  localparam logic [31:0] INST_SLT   = 32'h0001_0000;
  localparam logic [31:0] INST_SLTU  = 32'h0002_0000;
  localparam logic [31:0] INST_XOR   = 32'h0004_0000;
  localparam logic [31:0] INST_OR    = 32'h0008_0000;
  localparam logic [31:0] INST_AND   = 32'h0010_0000;
  localparam logic [31:0] INST_SRAI  = 32'h0040_0000;
  localparam logic [31:0] INST_SRLI  = 32'h0080_0000;
  localparam logic [31:0] INST_SLLI  = 32'h0100_0000;
  localparam logic [31:0] INST_ANDI  = 32'h0200_0000;
  localparam logic [31:0] INST_ORI   = 32'h0400_0000;
  localparam logic [31:0] INST_XORI  = 32'h0800_0000;

  // Sequencer states, kept as plain constants for legacy tool flows.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;

  // Loads are the only classes that must wait for a memory response.
  function automatic logic is_load(input logic [31:0] inst_type);
    return (inst_type == INST_LW) || (inst_type == INST_LBU);
  endfunction

endpackage

// File: rtl/wbu_commit_ctrl_if.sv
// Execute-side, memory-response and commit-side signals of the sequencer.
// The slave modport is the sequencer's view; master is its environment.
interface wbu_commit_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst_type;
  logic [31:0] result;
  logic [31:0] snpc;
  logic [4:0]  rd;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_wen;
  logic [31:0] dnpc;
  logic        commit;
  logic [31:0] retire_cnt;
  logic        err_illegal;
  logic        err_timeout;

  modport slave (
    input  in_valid, inst_type, result, snpc, rd, mem_rvalid, mem_rdata,
    output in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, pc_wen, dnpc,
           commit, retire_cnt, err_illegal, err_timeout
  );

  modport master (
    output in_valid, inst_type, result, snpc, rd, mem_rvalid, mem_rdata,
    input  in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, pc_wen, dnpc,
           commit, retire_cnt, err_illegal, err_timeout
  );
endinterface

// File: rtl/wbu_wdata_sel.sv
// Combinational class decode: picks register write data, next PC and write
// enable for the instruction being committed, and flags illegal class codes.
module wbu_wdata_sel
  import wbu_commit_ctrl_pkg::*;
(
  input  logic [31:0] inst_type_i,
  input  logic [31:0] result_i,
  input  logic [31:0] snpc_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] mem_word_i,
  output logic        rf_wen_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] dnpc_o,
  output logic        illegal_o
);

  logic wen_raw;

  // Decode the one-hot class into data/PC selection.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wen_raw    = 1'b1;
    rf_wdata_o = result_i;
    dnpc_o     = snpc_i;
    illegal_o  = 1'b0;
    case (inst_type_i)
      INST_JAL, INST_JALR: begin
        rf_wdata_o = snpc_i;
        dnpc_o     = result_i;
      end
      INST_BEQ, INST_BNE: begin
        wen_raw = 1'b0;
        dnpc_o  = result_i;
      end
      INST_LW:  rf_wdata_o = mem_word_i;
      // Byte lane chosen by the low address bits, zero-extended.
      INST_LBU: rf_wdata_o = {24'd0, mem_word_i[8*result_i[1:0] +: 8]};
      INST_ADDI, INST_ADD, INST_SUB, INST_LUI, INST_AUIPC,
      INST_SLTI, INST_SLTIU, INST_SLT, INST_SLTU,
      INST_XOR, INST_OR, INST_AND, INST_XORI, INST_ORI, INST_ANDI,
      INST_SRAI, INST_SRLI, INST_SLLI: rf_wdata_o = result_i;
      default: begin
        // Zero, multi-hot or unknown code: retire without side effects.
        wen_raw   = 1'b0;
        illegal_o = 1'b1;
      end
    endcase
  end

  // x0 is hardwired to zero, so writes to it are suppressed.
  assign rf_wen_o = wen_raw && (rd_i != 5'd0);

endmodule

// File: rtl/wbu_commit_ctrl.sv
// Multi-cycle commit sequencer between execute and register file/PC.
// Accepts one instruction, waits for load data when needed (with timeout),
// then issues a single-cycle commit: RF write, PC update and retire pulse.
module wbu_commit_ctrl
  import wbu_commit_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wbu_commit_ctrl_if.slave     bus
);

  // Counter value of the last WAIT_MEM cycle before the load is abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [1:0]      state_q,       state_d;
  logic [31:0]     inst_q,        inst_d;
  logic [31:0]     result_q,      result_d;
  logic [31:0]     snpc_q,        snpc_d;
  logic [4:0]      rd_q,          rd_d;
  logic [31:0]     mem_q,         mem_d;
  logic [TO_W-1:0] to_cnt_q,      to_cnt_d;
  logic [31:0]     retire_q,      retire_d;
  logic            err_illegal_q, err_illegal_d;
  logic            err_timeout_q, err_timeout_d;
  logic [4:0]      waddr_hold_q,  waddr_hold_d;
  logic [31:0]     wdata_hold_q,  wdata_hold_d;
  logic [31:0]     dnpc_hold_q,   dnpc_hold_d;

  logic            dec_wen;
  logic [31:0]     dec_wdata;
  logic [31:0]     dec_dnpc;
  logic            dec_illegal;
  logic            in_commit;

  wbu_wdata_sel u_wdata_sel (
    .inst_type_i (inst_q),
    .result_i    (result_q),
    .snpc_i      (snpc_q),
    .rd_i        (rd_q),
    .mem_word_i  (mem_q),
    .rf_wen_o    (dec_wen),
    .rf_wdata_o  (dec_wdata),
    .dnpc_o      (dec_dnpc),
    .illegal_o   (dec_illegal)
  );

  assign in_commit = (state_q == ST_COMMIT);

  // Next-state logic: accept, wait for load data or time out, then commit.
  always_comb begin
    state_d       = state_q;
    inst_d        = inst_q;
    result_d      = result_q;
    snpc_d        = snpc_q;
    rd_d          = rd_q;
    mem_d         = mem_q;
    to_cnt_d      = to_cnt_q;
    retire_d      = retire_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    waddr_hold_d  = waddr_hold_q;
    wdata_hold_d  = wdata_hold_q;
    dnpc_hold_d   = dnpc_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          inst_d   = bus.inst_type;
          result_d = bus.result;
          snpc_d   = bus.snpc;
          rd_d     = bus.rd;
          to_cnt_d = '0;
          state_d  = is_load(bus.inst_type) ? ST_WAIT_MEM : ST_COMMIT;
        end
      end
      ST_WAIT_MEM: begin
        to_cnt_d = to_cnt_q + 1'b1;
        // A response arriving on the final allowed cycle still wins.
        if (bus.mem_rvalid) begin
          mem_d   = bus.mem_rdata;
          state_d = ST_COMMIT;
        end else if (to_cnt_q == TO_LAST) begin
          mem_d         = '0;
          err_timeout_d = 1'b1;
          state_d       = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        retire_d      = retire_q + 32'd1;
        err_illegal_d = err_illegal_q | dec_illegal;
        waddr_hold_d  = rd_q;
        wdata_hold_d  = dec_wdata;
        dnpc_hold_d   = dec_dnpc;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: captured operands are reset too, so outputs are defined from
    // reset and a reset mid-flight leaves nothing stale to commit.
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      inst_q        <= '0;
      result_q      <= '0;
      snpc_q        <= '0;
      rd_q          <= '0;
      mem_q         <= '0;
      to_cnt_q      <= '0;
      retire_q      <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      waddr_hold_q  <= '0;
      wdata_hold_q  <= '0;
      dnpc_hold_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      state_q       <= state_d;
      inst_q        <= inst_d;
      result_q      <= result_d;
      snpc_q        <= snpc_d;
      rd_q          <= rd_d;
      mem_q         <= mem_d;
      to_cnt_q      <= to_cnt_d;
      retire_q      <= retire_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      waddr_hold_q  <= waddr_hold_d;
      wdata_hold_q  <= wdata_hold_d;
      dnpc_hold_q   <= dnpc_hold_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.mem_rready  = (state_q == ST_WAIT_MEM);
  assign bus.rf_wen      = in_commit && dec_wen;
  assign bus.pc_wen      = in_commit;
  assign bus.commit      = in_commit;
  // Write index/data and next PC show the live decode while committing and
  // hold the last committed values at all other times.
  assign bus.rf_waddr    = in_commit ? rd_q      : waddr_hold_q;
  assign bus.rf_wdata    = in_commit ? dec_wdata : wdata_hold_q;
  assign bus.dnpc        = in_commit ? dec_dnpc  : dnpc_hold_q;
  assign bus.retire_cnt  = retire_q;
  // The illegal flag is visible already during the offending commit.
  assign bus.err_illegal = err_illegal_q || (in_commit && dec_illegal);
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_wbu_commit_ctrl.sv
// Scoreboard bench for wbu_commit_ctrl: the driver pushes the expected commit
// for each issued instruction, a monitor pops and compares on every commit.
module tb_wbu_commit_ctrl;
  import wbu_commit_ctrl_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wbu_commit_ctrl_if bus ();

  wbu_commit_ctrl #(.MEM_TIMEOUT(T), .TO_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] dnpc;
    logic [31:0] retire;
    logic        ill;
    logic        eill;
    logic        eto;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  logic [31:0] m_retire = '0;
  logic        m_ill = 1'b0;
  logic        m_to  = 1'b0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_dnpc  = '0;

  logic [31:0] codes [24] = '{
    INST_ADDI, INST_JALR, INST_ADD, INST_LUI, INST_LW, INST_LBU, INST_AUIPC,
    INST_JAL, INST_SUB, INST_SLTI, INST_SLTIU, INST_BEQ, INST_BNE, INST_SLT,
    INST_SLTU, INST_XOR, INST_OR, INST_AND, INST_SRAI, INST_SRLI, INST_SLLI,
    INST_ANDI, INST_ORI, INST_XORI
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
  endtask

  // Reference behaviour of one retired instruction, from the class rules.
  function automatic exp_t model(input logic [31:0] code, input logic [31:0] res,
                                 input logic [31:0] sn, input logic [4:0] r,
                                 input logic [31:0] word, input bit timed_out);
    exp_t e;
    logic [31:0] data;
    data    = timed_out ? 32'd0 : word;
    e.cyc   = 0;
    e.waddr = r;
    e.wen   = 1'b1;
    e.wdata = res;
    e.dnpc  = sn;
    e.ill   = 1'b0;
    e.retire = '0;
    e.eill  = 1'b0;
    e.eto   = 1'b0;
    if (code == INST_JAL || code == INST_JALR) begin
      e.wdata = sn;
      e.dnpc  = res;
    end else if (code == INST_BEQ || code == INST_BNE) begin
      e.wen  = 1'b0;
      e.dnpc = res;
    end else if (code == INST_LW) begin
      e.wdata = data;
    end else if (code == INST_LBU) begin
      e.wdata = (data >> (8 * res[1:0])) & 32'hFF;
    end else begin
      bit found = 1'b0;
      foreach (codes[i]) if (codes[i] == code) found = 1'b1;
      if (!found) begin
        e.wen = 1'b0;
        e.ill = 1'b1;
      end
    end
    if (r == 5'd0) e.wen = 1'b0;
    return e;
  endfunction

  // Issue one instruction; delay is the WAIT_MEM cycle carrying mem_rvalid,
  // values above T let the load time out.
  task automatic send(input logic [31:0] code, input logic [31:0] res,
                      input logic [31:0] sn, input logic [4:0] r,
                      input int delay, input logic [31:0] rdata);
    exp_t e;
    int   a;
    int   waits;
    bit   load;
    bit   to;
    load = (code == INST_LW) || (code == INST_LBU);
    to   = load && (delay > T);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.inst_type  = code;
    bus.result     = res;
    bus.snpc       = sn;
    bus.rd         = r;
    bus.mem_rvalid = ($urandom_range(0, 1) == 1);
    bus.mem_rdata  = $urandom;
    waits = 0;
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      n_total++;
      $display("FAIL accept_wait: in_ready never rose within 50 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    e = model(code, res, sn, r, rdata, to);
    e.cyc = load ? a + (to ? T : delay) : a;
    m_ill = m_ill | e.ill;
    m_to  = m_to | to;
    e.eill   = m_ill;
    e.eto    = m_to;
    e.retire = m_retire;
    m_retire = m_retire + 32'd1;
    sb.push_back(e);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.inst_type  = $urandom;
    bus.result     = $urandom;
    bus.snpc       = $urandom;
    if (load) begin
      for (int k = 1; k <= (to ? T : delay); k++) begin
        check("mem_rready_wait", bus.mem_rready, 1);
        if (!to && k == delay) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdata;
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
    end
  endtask

  // Monitor: compare every commit against the scoreboard head, and check
  // strobes stay low and index/PC hold between commits.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.commit === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_commit @cyc %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("commit_cycle", cyc, e.cyc);
          check("pc_wen", bus.pc_wen, 1);
          check("in_ready_commit", bus.in_ready, 0);
          check("mem_rready_commit", bus.mem_rready, 0);
          check("rf_wen", bus.rf_wen, e.wen);
          check("rf_waddr", bus.rf_waddr, e.waddr);
          if (e.wen) check("rf_wdata", bus.rf_wdata, e.wdata);
          check("dnpc", bus.dnpc, e.dnpc);
          check("retire_cnt", bus.retire_cnt, e.retire);
          check("err_illegal", bus.err_illegal, e.eill);
          check("err_timeout", bus.err_timeout, e.eto);
          last_waddr = e.waddr;
          last_dnpc  = e.dnpc;
        end
      end else begin
        check("rf_wen_idle", bus.rf_wen, 0);
        check("pc_wen_idle", bus.pc_wen, 0);
        check("dnpc_hold", bus.dnpc, last_dnpc);
        check("rf_waddr_hold", bus.rf_waddr, last_waddr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    bus.in_valid   = 1'b0;
    bus.inst_type  = '0;
    bus.result     = '0;
    bus.snpc       = '0;
    bus.rd         = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_mem_rready", bus.mem_rready, 0);
    check("rst_commit", bus.commit, 0);
    check("rst_retire", bus.retire_cnt, 0);
    check("rst_err_illegal", bus.err_illegal, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    rst_n = 1'b1;

    // Directed cases.
    send(INST_ADDI, 32'h10, 32'h8000_0004, 5'd5, 0, 0);
    send(INST_JAL, 32'h8000_0100, 32'h8000_0008, 5'd1, 0, 0);
    send(INST_JAL, 32'h8000_0100, 32'h8000_0008, 5'd0, 0, 0);
    send(INST_LBU, 32'h8000_1002, 32'h8000_0010, 5'd7, 3, 32'hAABB_CCDD);
    send(INST_BNE, 32'h8000_0040, 32'h8000_0014, 5'd3, 0, 0);
    send(INST_BEQ, 32'h8000_0040, 32'h8000_0018, 5'd3, 0, 0);
    send(INST_LW, 32'h8000_2000, 32'h8000_001C, 5'd9, T + 1, 32'h1234_5678);
    send(32'h3, 32'h5555_0000, 32'h8000_0020, 5'd4, 0, 0);
    send(INST_LW, 32'h8000_2004, 32'h8000_0024, 5'd10, T, 32'hCAFE_F00D);
    send(INST_LBU, 32'h8000_2007, 32'h8000_0028, 5'd11, 1, 32'h8899_AABB);

    // Reset while a load waits for memory: nothing may commit.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.inst_type = INST_LW;
    bus.result    = 32'h8000_3000;
    bus.rd        = 5'd12;
    waits = 0;
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_waiting", bus.mem_rready, 1);
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    m_retire   = '0;
    m_ill      = 1'b0;
    m_to       = 1'b0;
    last_waddr = '0;
    last_dnpc  = '0;
    @(negedge clk);
    check("rst_mid_in_ready", bus.in_ready, 1);
    check("rst_mid_mem_rready", bus.mem_rready, 0);
    check("rst_mid_retire", bus.retire_cnt, 0);
    check("rst_mid_err_illegal", bus.err_illegal, 0);
    check("rst_mid_err_timeout", bus.err_timeout, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_after_retire", bus.retire_cnt, 0);

    // Five commits from zero.
    for (int i = 0; i < 5; i++)
      send(INST_ADD, 32'h100 + i, 32'h8000_0100 + 4 * i, 5'(i + 1), 0, 0);
    @(negedge clk);
    check("retire_after_5", bus.retire_cnt, 5);

    // Randomized traffic, including illegal codes and load timeouts.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] code;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       code = 32'h0;
          1:       code = 32'h3;
          2:       code = 32'h4;
          default: code = $urandom;
        endcase
      end else begin
        code = codes[$urandom_range(0, 23)];
      end
      send(code, $urandom, $urandom, 5'($urandom_range(0, 31)),
           $urandom_range(1, T + 1), $urandom);
    end

    waits = 0;
    while (sb.size() != 0 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected commits never seen", sb.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
